// File: rtl/cruise_ctrl_gen2.sv
// -----------------------------------------------------------------------------
// cruise_ctrl_gen2
//   Second-generation cruise controller. Holds a driver setpoint (vout),
//   compares it with measured speed every cycle and requests a graded
//   throttle or the brake. Adds saturating setpoint adjustment, a brake-pedal
//   cancel and a drowsiness watchdog that forces a braking FAULT state.
//
//   Optional feature macro: CRUISE_RAMP_EN
//     defined   : commands update an internal target; vout slews toward it by
//                 STEP per cycle while in HOLD and freezes in IDLE/FAULT.
//     undefined : vout is the target and changes on the command edge.
//
// Ports
//   clock    in      rising-edge clock
//   reset    in      synchronous, active-high reset
//   speed    in  W   measured speed
//   vset     in  W   requested setpoint, loaded on SET
//   alert    in  3   drowsiness level (0 = fully alert)
//   change   in  2   00 none, 01 INC, 10 DEC, 11 SET
//   pedal    in      brake pedal (cancel)
//   brake    out     brake request
//   throttle out 3   throttle level 0..7
//   gt/eq/lt out     speed >, =, < vout
//   vout     out W   active setpoint
//   engaged  out     high in HOLD
//   fault    out     high in FAULT
// -----------------------------------------------------------------------------
module cruise_ctrl_gen2 #(
  parameter int W          = 8,
  parameter int STEP       = 1,
  parameter int TOL        = 2,
  parameter int VMAX       = 200,
  parameter int ALERT_TRIP = 6,
  parameter int ALERT_CYC  = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] speed,
  input  logic [W-1:0] vset,
  input  logic [2:0]   alert,
  input  logic [1:0]   change,
  input  logic         pedal,
  output logic         brake,
  output logic [2:0]   throttle,
  output logic         gt,
  output logic         eq,
  output logic         lt,
  output logic [W-1:0] vout,
  output logic         engaged,
  output logic         fault
);

  // One extra bit keeps every sum and difference free of wrap-around.
  localparam int WP = W + 1;
  localparam int CW = $clog2(ALERT_CYC + 1);

  localparam logic [WP-1:0] STEP_X = WP'(STEP);
  localparam logic [WP-1:0] TOL_X  = WP'(TOL);
  localparam logic [WP-1:0] VMAX_X = WP'(VMAX);
  localparam logic [CW-1:0] CYC_X  = CW'(ALERT_CYC);

  localparam logic [1:0] CMD_INC = 2'b01;
  localparam logic [1:0] CMD_DEC = 2'b10;
  localparam logic [1:0] CMD_SET = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, FAULT = 2'd2} state_t;

  state_t        state;
  logic [CW-1:0] drowsy_cnt, clear_cnt;
  logic [CW-1:0] drowsy_nxt, clear_nxt;
  logic          is_drowsy;

  logic [WP-1:0] vout_x, speed_x, base_x;
  logic [WP-1:0] set_x, inc_x, dec_x, cmd_x;
  logic [WP-1:0] diff_q;
  logic [2:0]    throttle_law;
  logic          brake_law;

`ifdef CRUISE_RAMP_EN
  logic [W-1:0]  target;
  logic [WP-1:0] target_x, ramp_x;
  assign target_x = WP'(target);
  assign base_x   = target_x;
`else
  assign base_x   = vout_x;
`endif

  assign vout_x    = WP'(vout);
  assign speed_x   = WP'(speed);
  assign is_drowsy = (alert >= 3'(ALERT_TRIP));

  // Watchdog counters: saturate at ALERT_CYC, clear on the opposite condition.
  // FSM decisions use the post-increment value so FAULT is entered on the
  // very edge the count reaches ALERT_CYC.
  assign drowsy_nxt = !is_drowsy ? '0 :
                      (drowsy_cnt == CYC_X) ? drowsy_cnt : drowsy_cnt + CW'(1);
  assign clear_nxt  = is_drowsy ? '0 :
                      (clear_cnt == CYC_X) ? clear_cnt : clear_cnt + CW'(1);

  // Setpoint arithmetic, saturating at 0 and VMAX.
  assign set_x = (WP'(vset) > VMAX_X) ? VMAX_X : WP'(vset);
  assign inc_x = (base_x + STEP_X > VMAX_X) ? VMAX_X : base_x + STEP_X;
  assign dec_x = (base_x < STEP_X) ? '0 : base_x - STEP_X;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    cmd_x = base_x;
    unique case (change)
      CMD_SET: cmd_x = set_x;
      CMD_INC: cmd_x = inc_x;
      CMD_DEC: cmd_x = dec_x;
      default: cmd_x = base_x;
    endcase
  end

  // Control law on the registered (pre-update) setpoint.
  always_comb begin
    brake_law    = 1'b0;
    throttle_law = 3'd0;
    diff_q       = (vout_x - speed_x) >> 2;
    if (speed_x > vout_x + TOL_X) begin
      brake_law = 1'b1;
    end else if (speed_x + TOL_X < vout_x) begin
      if (diff_q == '0)              throttle_law = 3'd1;
      else if (diff_q > WP'(7))      throttle_law = 3'd7;
      else                           throttle_law = diff_q[2:0];
    end
  end

`ifdef CRUISE_RAMP_EN
  always_comb begin
    ramp_x = vout_x;
    if (vout_x < target_x)
      ramp_x = (vout_x + STEP_X > target_x) ? target_x : vout_x + STEP_X;
    else if (vout_x > target_x)
      ramp_x = (vout_x < target_x + STEP_X) ? target_x : vout_x - STEP_X;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      drowsy_cnt <= '0;
      clear_cnt  <= '0;
      vout       <= '0;
      brake      <= 1'b0;
      throttle   <= 3'd0;
      gt         <= 1'b0;
      eq         <= 1'b0;
      lt         <= 1'b0;
      engaged    <= 1'b0;
      fault      <= 1'b0;
`ifdef CRUISE_RAMP_EN
      target     <= '0;
`endif
    end else begin
      drowsy_cnt <= drowsy_nxt;
      clear_cnt  <= clear_nxt;
      gt         <= (speed >  vout);
      eq         <= (speed == vout);
      lt         <= (speed <  vout);
      // Outputs default to the IDLE values; each branch overrides.
      brake      <= 1'b0;
      throttle   <= 3'd0;
      engaged    <= 1'b0;
      fault      <= 1'b0;
`ifdef CRUISE_RAMP_EN
      if (state == HOLD) vout <= ramp_x[W-1:0];
`endif
      unique case (state)
        IDLE: begin
          if (change == CMD_SET) begin
            state   <= HOLD;
            engaged <= 1'b1;
`ifdef CRUISE_RAMP_EN
            target  <= set_x[W-1:0];
`else
            vout    <= set_x[W-1:0];
`endif
          end
        end
        HOLD: begin
          if (drowsy_nxt == CYC_X) begin
            state <= FAULT;
            brake <= 1'b1;
            fault <= 1'b1;
          end else if (pedal) begin
            state <= IDLE;
          end else begin
            engaged  <= 1'b1;
            brake    <= brake_law;
            throttle <= throttle_law;
`ifdef CRUISE_RAMP_EN
            target   <= cmd_x[W-1:0];
`else
            vout     <= cmd_x[W-1:0];
`endif
          end
        end
        FAULT: begin
          if (clear_nxt == CYC_X) begin
            state <= IDLE;
          end else begin
            brake <= 1'b1;
            fault <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cruise_ctrl_gen2.sv
module tb_cruise_ctrl_gen2;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] speed, vset;
  logic [2:0] alert;
  logic [1:0] change;
  logic       pedal;
  logic       brake, gt, eq, lt, engaged, fault;
  logic [2:0] throttle;
  logic [7:0] vout;

  int n_tests = 0;
  int n_fail  = 0;

  cruise_ctrl_gen2 dut (
    .clock(clock), .reset(reset), .speed(speed), .vset(vset), .alert(alert),
    .change(change), .pedal(pedal), .brake(brake), .throttle(throttle),
    .gt(gt), .eq(eq), .lt(lt), .vout(vout), .engaged(engaged), .fault(fault)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model (plain integer arithmetic) ----------
  // Modes: 0 idle, 1 cruising, 2 fault.
  int m_mode, m_vout, m_drowsy, m_clear;
  int e_brake, e_thr, e_gt, e_eq, e_lt, e_eng, e_fault;
  bit started = 0;

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  always @(posedge clock) begin
    int sp, old_v;
    started = 1;
    if (reset) begin
      m_mode = 0; m_vout = 0; m_drowsy = 0; m_clear = 0;
      e_brake = 0; e_thr = 0; e_gt = 0; e_eq = 0; e_lt = 0; e_eng = 0; e_fault = 0;
    end else begin
      sp    = int'(speed);
      old_v = m_vout;
      e_gt  = (sp > old_v); e_eq = (sp == old_v); e_lt = (sp < old_v);
      if (alert >= 6) begin m_drowsy = clamp(m_drowsy + 1, 0, 4); m_clear = 0; end
      else            begin m_clear  = clamp(m_clear + 1, 0, 4);  m_drowsy = 0; end
      e_brake = 0; e_thr = 0;
      case (m_mode)
        0: if (change == 2'b11) begin m_vout = clamp(int'(vset), 0, 200); m_mode = 1; end
        1: begin
          if (m_drowsy == 4)  m_mode = 2;
          else if (pedal)     m_mode = 0;
          else begin
            if (sp > old_v + 2)      e_brake = 1;
            else if (sp + 2 < old_v) e_thr = clamp((old_v - sp) / 4, 1, 7);
            case (change)
              2'b11: m_vout = clamp(int'(vset), 0, 200);
              2'b01: m_vout = clamp(old_v + 1, 0, 200);
              2'b10: m_vout = clamp(old_v - 1, 0, 200);
              default: ;
            endcase
          end
        end
        default: if (m_clear == 4) m_mode = 0;
      endcase
      if (m_mode == 2) e_brake = 1;
      e_eng   = (m_mode == 1);
      e_fault = (m_mode == 2);
    end
  end

  // ---------------- per-cycle compare -------------------------------------
  always @(negedge clock) begin
    if (started) begin
      check("brake",    32'(brake),    32'(e_brake));
      check("throttle", 32'(throttle), 32'(e_thr));
      check("gt",       32'(gt),       32'(e_gt));
      check("eq",       32'(eq),       32'(e_eq));
      check("lt",       32'(lt),       32'(e_lt));
      check("vout",     32'(vout),     32'(m_vout));
      check("engaged",  32'(engaged),  32'(e_eng));
      check("fault",    32'(fault),    32'(e_fault));
    end
  end

  // One clock: inputs set now are sampled at the next rising edge; returns
  // shortly after the following falling edge with outputs settled.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
      #1;
    end
  endtask

  // ---------------- directed stimulus with literal expectations -----------
  initial begin
    reset = 1; speed = 0; vset = 0; alert = 0; change = 0; pedal = 0;
    tick(2);
    check("rst_vout", 32'(vout), 0);
    check("rst_outs", {brake, throttle, gt, eq, lt, engaged, fault}, 0);

    // IDLE ignores INC.
    reset = 0; change = 2'b01; tick();
    check("idle_inc_vout", 32'(vout), 0);
    check("idle_inc_eng",  32'(engaged), 0);

    // SET 136 at speed 136.
    change = 2'b11; vset = 136; speed = 136; tick();
    check("set_eng",  32'(engaged), 1);
    check("set_vout", 32'(vout), 136);
    change = 2'b00; tick();
    check("hold_eq",  32'(eq), 1);
    check("hold_thr0", 32'(throttle), 0);
    check("hold_brk0", 32'(brake), 0);

    // Control law.
    speed = 100; tick();
    check("law100_thr", 32'(throttle), 7);
    check("law100_lt",  32'(lt), 1);
    speed = 130; tick();
    check("law130_thr", 32'(throttle), 1);
    speed = 137; tick();
    check("law137_thr", 32'(throttle), 0);
    check("law137_brk", 32'(brake), 0);
    check("law137_gt",  32'(gt), 1);
    speed = 140; tick();
    check("law140_brk", 32'(brake), 1);

    // Setpoint saturation.
    change = 2'b11; vset = 250; tick();
    check("set_clamp", 32'(vout), 200);
    change = 2'b01; tick(3);
    check("inc_clamp", 32'(vout), 200);
    change = 2'b11; vset = 1; tick();
    check("set_one", 32'(vout), 1);
    change = 2'b10; tick(2);
    check("dec_floor", 32'(vout), 0);

    // Pedal cancel from HOLD.
    change = 2'b11; vset = 136; speed = 100; tick();
    change = 2'b00; tick();
    check("pre_pedal_thr", 32'(throttle), 7);
    pedal = 1; tick();
    check("pedal_eng", 32'(engaged), 0);
    check("pedal_thr", 32'(throttle), 0);
    pedal = 0;

    // Watchdog: FAULT wins over a concurrent pedal.
    speed = 136; change = 2'b11; tick();
    change = 2'b00; alert = 6; tick(3);
    check("wd3_fault", 32'(fault), 0);
    check("wd3_eng",   32'(engaged), 1);
    pedal = 1; tick();
    check("wd4_fault", 32'(fault), 1);
    check("wd4_brake", 32'(brake), 1);
    check("wd4_eng",   32'(engaged), 0);
    pedal = 0; alert = 0; change = 2'b01; tick(3);
    check("clr3_fault", 32'(fault), 1);
    tick();
    check("clr4_fault", 32'(fault), 0);
    check("clr4_brake", 32'(brake), 0);
    check("clr4_vout",  32'(vout), 136);

    // Interrupted drowsiness keeps HOLD.
    change = 2'b11; tick();
    change = 2'b00; alert = 6; tick(3);
    alert = 2; tick();
    alert = 6; tick(3);
    check("intr_eng",   32'(engaged), 1);
    check("intr_fault", 32'(fault), 0);
    tick();
    check("intr_fault2", 32'(fault), 1);
    check("intr_brake",  32'(brake), 1);

    // Reset from FAULT.
    reset = 1; tick();
    check("rst2_outs", {brake, throttle, gt, eq, lt, engaged, fault}, 0);
    check("rst2_vout", 32'(vout), 0);
    reset = 0; alert = 0; tick(2);
    check("rst2_idle", 32'(engaged), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cruise_ctrl_gen2.md
# cruise_ctrl_gen2

Parametrised second-generation cruise controller. It holds a driver-requested setpoint, compares it against measured vehicle speed each cycle, and drives a graded throttle or the brake. It adds saturating setpoint adjustment, a brake-pedal cancel, and a drowsiness watchdog that forces a braking fault state. It sits between the speed-sensor interface and the actuator drivers, clocked by the system `clock`.

## Interface
Parameters:
- `W`, 8, speed/setpoint width in bits (unsigned)
- `STEP`, 1, setpoint increment/decrement per command
- `TOL`, 2, dead band around the setpoint (speed units)
- `VMAX`, 200, setpoint ceiling
- `ALERT_TRIP`, 6, drowsiness level at or above which a cycle counts as "drowsy"
- `ALERT_CYC`, 4, consecutive drowsy/clear cycles needed to enter/leave FAULT

Ports:
- `clock` in 1: rising-edge clock, the only clock
- `reset` in 1: synchronous, active-high
- `speed` in W: measured speed
- `vset` in W: requested setpoint, loaded on SET
- `alert` in 3: driver drowsiness level (0 = fully alert)
- `change` in 2: command; 00 none, 01 INC, 10 DEC, 11 SET
- `pedal` in 1: brake pedal pressed (cancel)
- `brake` out 1: brake request
- `throttle` out 3: throttle level, 0..7
- `gt`, `eq`, `lt` out 1 each: speed >, =, < `vout`
- `vout` out W: active setpoint
- `engaged` out 1: high in HOLD
- `fault` out 1: high in FAULT

## Operation
- States: IDLE, HOLD, FAULT. Reset → IDLE.
- Reset values: `brake`=0, `throttle`=0, `gt`=`eq`=`lt`=0, `vout`=0, `engaged`=0, `fault`=0, counters 0.
- Drowsy counter: increments (saturating at ALERT_CYC) each cycle `alert`≥ALERT_TRIP. It clears to 0 on any cycle below the trip level. A clear counter works the same way with the inverse condition.
- IDLE: `throttle`=0, `brake`=0, `vout` holds. SET loads `vout`=min(`vset`,VMAX) and goes to HOLD. INC, DEC and `pedal` are ignored.
- HOLD, with priority highest first:
  - Drowsy counter reaching ALERT_CYC → FAULT.
  - `pedal`=1 → IDLE.
  - SET reloads min(`vset`,VMAX).
  - INC: `vout`=min(`vout`+STEP, VMAX).
  - DEC: `vout`=max(`vout`−STEP, 0).
  - Arithmetic is W+1 bits, so there is no wrap-around.
- Control law, HOLD only, using the current registered `vout` and the sampled `speed`:
  - `speed` > `vout`+TOL → `brake`=1, `throttle`=0.
  - `speed`+TOL < `vout` → `brake`=0, `throttle`=min(max((`vout`−`speed`)>>2, 1), 7).
  - Otherwise both are 0.
  - All sums are W+1 bits.
- FAULT: `brake`=1, `throttle`=0, `engaged`=0, `fault`=1. All commands and `pedal` are ignored. The clear counter reaching ALERT_CYC → IDLE, which loses the setpoint engagement but keeps the `vout` value.
- Comparator flags: `gt`/`eq`/`lt` are updated every cycle in every state, exactly one high after the first post-reset edge.
- Leaving HOLD for any reason drops `throttle` to 0 on the same edge.

## Timing
- All outputs are registered. Inputs are sampled on the rising edge of `clock`.
- Command → `vout` and state: 1 cycle.
- Command → control outputs: 2 cycles, because the control law uses the pre-update `vout`.
- `speed` → `brake`/`throttle`/flags: 1 cycle.
- Watchdog: FAULT is entered on the edge where the drowsy count reaches ALERT_CYC. `alert` held high from edge n gives `fault`=1 after edge n+ALERT_CYC−1.
- `reset` asserted mid-operation returns every output to its reset value on the next edge, overriding all inputs.

## Configuration
- `CRUISE_RAMP_EN` defined:
  - SET/INC/DEC update an internal target.
  - `vout` moves toward the target by STEP per cycle, clamped to the target, while in HOLD.
  - In IDLE and FAULT, `vout` freezes.
- Not defined: `vout` is the target itself and updates on the command edge.

## Test plan
- Defaults. Reset, then SET with `vset`=136 and `speed`=136 → next edge `engaged`=1, `vout`=136. One edge later: `eq`=1, `throttle`=0, `brake`=0.
- HOLD, `vout`=136:
  - `speed`=100 → `throttle`=7, `lt`=1.
  - `speed`=130 → `throttle`=1.
  - `speed`=137 → `throttle`=0, `brake`=0, `gt`=1.
  - `speed`=140 → `brake`=1.
- SET with `vset`=250 → `vout`=200. INC ×3 → `vout`=200. DEC from `vout`=1 twice → `vout`=0.
- HOLD with `alert`=6 for 4 cycles, `pedal`=1 concurrently → FAULT (not IDLE), `brake`=1, `fault`=1. `alert`=0 for 4 cycles → IDLE, `fault`=0, `brake`=0.
- `alert`=6 for 3 cycles, then 2, then 6 for 3 → stays in HOLD.
- `reset` pulse while in FAULT, with `brake`=1 → next edge all outputs 0, state IDLE.
